fp_mult_core_seq: RTL
=====================

Name: fp_mult_core_seq

Overview:
- Front-end of the single-precision FPU multiplier; it feeds the normalization stage.
- Accepts two IEEE-754 binary32 operands over a valid/ready handshake and unpacks them.
- Multiplies the 24-bit significands (hidden bit included) with an iterative shift-add over 24 cycles.
- Emits the raw upper product, sticky bit, biased exponent sum, sign and exception flags for the normalizer, which consumes fraction[23] as its shift indicator.

Parameters:
- MANT_W, 23, stored fraction width; the significand is MANT_W+1 bits.
- EXP_W, 8, exponent field width.
- BIAS, 127, exponent bias subtracted from the exponent sum.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand pair present.
- in_ready  out  1  block idle and able to accept.
- a  in  32  operand A, binary32.
- b  in  32  operand B, binary32.
- out_valid  out  1  result present.
- out_ready  in  1  downstream (normalizer) accepts the result.
- fraction  out  24  product[47:24] of the 48-bit significand product.
- sticky  out  1  OR-reduction of product[23:0].
- exponent  out  8  ea+eb-BIAS, saturated.
- sign  out  1  a[31] XOR b[31].
- zero  out  1  result is an exact zero.
- exp_overflow  out  1  exponent sum ≥255 or an operand is Inf/NaN.
- exp_underflow  out  1  exponent sum ≤0.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- While rst_n=0: state=IDLE; out_valid, fraction, sticky, exponent, sign, zero, exp_overflow, exp_underflow, iteration counter and accumulator all 0. Inputs are ignored until rst_n=1.
- Reset asserted mid-operation aborts immediately; no partial result is ever presented.
- FSM states: IDLE, MUL, HOLD. in_ready = (state==IDLE).
- IDLE, on accept edge (in_valid & in_ready):
  - Register sign.
  - Compute signed 10-bit sum s = ea+eb-BIAS.
  - Load ma={1,fa} and mb={1,fb}. Clear the 48-bit accumulator. counter=0.
- Special operands:
  - Exponent field 0 (zero or subnormal, flushed) on either operand → zero=1.
  - Exponent field 255 on either operand → exp_overflow=1.
  - Inf×0 sets both zero=1 and exp_overflow=1; the downstream normalizer treats this combination as invalid.
  - Any special case: fraction=0, sticky=0, exponent = 255 if overflow else 0. Skip MUL and go straight to HOLD; out_valid is visible the cycle after accept.
- Normal case, go to MUL:
  - Each MUL edge: if mb[0], add ma into accumulator bits [47:24] with carry. Shift the {carry, accumulator} pair right by 1. Shift mb right by 1. counter++.
  - After the edge with counter==23, go to HOLD. out_valid becomes visible exactly 24 edges after the accept edge.
- Exponent rules:
  - s ≥ 255 → exponent=0xFF, exp_overflow=1.
  - s ≤ 0 → exponent=0x00, exp_underflow=1.
  - Otherwise exponent=s[7:0].
  - No normalization increment here; that belongs to the normalizer.
- Product range: a normal product lies in [1,4), so fraction[23:22] ≠ 00.
- HOLD:
  - out_valid=1; all outputs held stable until out_valid & out_ready. On that edge go to IDLE and deassert out_valid.
  - in_ready=0, so no new operand is accepted in the same cycle; there is no overlap and no pipelining.
  - Any out_ready pulse outside HOLD is ignored.
- in_valid while busy: ignored; the upstream must hold its operands until in_ready.
- Throughput: 1 result per 26 cycles minimum for normal operands (accept, 24 MUL, HOLD with out_ready=1).

Test Plan:
- 1.0×1.0 (a=b=0x3F800000): out_valid 24 cycles after accept; fraction=0x400000, sticky=0, exponent=0x7F, sign=0, all flags 0.
- 1.5×1.5 (a=b=0x3FC00000) → fraction=0x900000, exponent=0x7F. Also -2.0×3.0 (0xC0000000, 0x40400000) → fraction=0x600000, exponent=0x81, sign=1.
- Sticky: a=b=0x3F800001 → fraction=0x400001, sticky=1, exponent=0x7F.
- Specials:
  - a=0x00000000, b=0x3F800000 → out_valid one cycle after accept, zero=1, fraction=0.
  - a=b=0x7F000000 → exp_overflow=1, exponent=0xFF.
  - a=b=0x00800000 → exp_underflow=1, exponent=0x00.
  - a=0x7F800000, b=0 → zero=1 and exp_overflow=1.
- Backpressure: hold out_ready=0 for 10 cycles in HOLD → outputs stable, in_ready=0, and a new in_valid is not accepted. Raise out_ready → IDLE next cycle; the next operand pair is then accepted and yields the correct result.
- Reset mid-MUL: drop rst_n at MUL iteration 10 → all outputs 0 asynchronously. After release, in_ready=1; a fresh 1.0×1.0 returns 0x400000 with no residue from the aborted operation.

Source files
------------

// File: rtl/fp_mult_core_seq.sv
// Single-precision multiplier front-end: unpacks two binary32 operands and forms the
// 48-bit significand product by 24-cycle shift-add, handing raw fields to the normalizer.
module fp_mult_core_seq #(
  parameter int MANT_W = 23,
  parameter int EXP_W  = 8,
  parameter int BIAS   = 127
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [MANT_W+EXP_W:0]   a,
  input  logic [MANT_W+EXP_W:0]   b,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [MANT_W:0]         fraction,
  output logic                    sticky,
  output logic [EXP_W-1:0]        exponent,
  output logic                    sign,
  output logic                    zero,
  output logic                    exp_overflow,
  output logic                    exp_underflow
);

  localparam int SIG_W  = MANT_W + 1;
  localparam int PROD_W = 2 * SIG_W;
  localparam int CNT_W  = $clog2(SIG_W);
  localparam int SUM_W  = EXP_W + 2;
  localparam logic signed [SUM_W-1:0] EXP_MAX_S  = SUM_W'((1 << EXP_W) - 1);
  localparam logic signed [SUM_W-1:0] EXP_ZERO_S = '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t                   state_r, state_next_s;
  logic [CNT_W-1:0]         cnt_r;
  logic [SIG_W-1:0]         ma_r, mb_r;
  logic [PROD_W-1:0]        acc_r;
  logic                     sign_r;
  logic signed [SUM_W-1:0]  exp_sum_r;

  logic [EXP_W-1:0]         ea_s, eb_s;
  logic                     zero_op_s, inf_op_s, special_s, accept_s, last_iter_s;
  logic signed [SUM_W-1:0]  exp_sum_s;
  logic [SIG_W:0]           add_s;
  logic [PROD_W-1:0]        acc_next_s;
  logic                     exp_ovf_s, exp_unf_s;

  assign ea_s      = a[MANT_W+EXP_W-1:MANT_W];
  assign eb_s      = b[MANT_W+EXP_W-1:MANT_W];
  assign zero_op_s = (ea_s == {EXP_W{1'b0}}) || (eb_s == {EXP_W{1'b0}});
  assign inf_op_s  = (ea_s == {EXP_W{1'b1}}) || (eb_s == {EXP_W{1'b1}});
  assign special_s = zero_op_s | inf_op_s;
  assign exp_sum_s = SUM_W'({2'b00, ea_s}) + SUM_W'({2'b00, eb_s}) - SUM_W'(BIAS);

  assign in_ready  = (state_r == IDLE);
  assign accept_s  = in_valid & in_ready;

  // One shift-add step: conditional add into the upper half, then shift {carry, acc} right.
  assign add_s       = {1'b0, acc_r[PROD_W-1:SIG_W]} + (mb_r[0] ? {1'b0, ma_r} : {(SIG_W+1){1'b0}});
  assign acc_next_s  = {add_s, acc_r[SIG_W-1:1]};
  assign last_iter_s = (cnt_r == CNT_W'(SIG_W - 1));
  assign exp_ovf_s   = (exp_sum_r >= EXP_MAX_S);
  assign exp_unf_s   = (exp_sum_r <= EXP_ZERO_S);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_next_s = special_s ? HOLD : MUL;
        end else begin
          state_next_s = IDLE;
        end
      end
      MUL: begin
        if (last_iter_s) begin
          state_next_s = HOLD;
        end else begin
          state_next_s = MUL;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = HOLD;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Datapath and result registers; results only load on entry to HOLD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r         <= '0;
      ma_r          <= '0;
      mb_r          <= '0;
      acc_r         <= '0;
      sign_r        <= 1'b0;
      exp_sum_r     <= '0;
      out_valid     <= 1'b0;
      fraction      <= '0;
      sticky        <= 1'b0;
      exponent      <= '0;
      sign          <= 1'b0;
      zero          <= 1'b0;
      exp_overflow  <= 1'b0;
      exp_underflow <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            sign_r    <= a[MANT_W+EXP_W] ^ b[MANT_W+EXP_W];
            exp_sum_r <= exp_sum_s;
            ma_r      <= {1'b1, a[MANT_W-1:0]};
            mb_r      <= {1'b1, b[MANT_W-1:0]};
            acc_r     <= '0;
            cnt_r     <= '0;
            if (special_s) begin
              out_valid     <= 1'b1;
              fraction      <= '0;
              sticky        <= 1'b0;
              exponent      <= inf_op_s ? {EXP_W{1'b1}} : {EXP_W{1'b0}};
              sign          <= a[MANT_W+EXP_W] ^ b[MANT_W+EXP_W];
              zero          <= zero_op_s;
              exp_overflow  <= inf_op_s;
              exp_underflow <= 1'b0;
            end
          end
        end
        MUL: begin
          acc_r <= acc_next_s;
          mb_r  <= mb_r >> 1;
          cnt_r <= cnt_r + CNT_W'(1);
          if (last_iter_s) begin
            out_valid     <= 1'b1;
            fraction      <= acc_next_s[PROD_W-1:SIG_W];
            sticky        <= |acc_next_s[SIG_W-1:0];
            sign          <= sign_r;
            zero          <= 1'b0;
            exp_overflow  <= exp_ovf_s;
            exp_underflow <= exp_unf_s & ~exp_ovf_s;
            if (exp_ovf_s) begin
              exponent <= {EXP_W{1'b1}};
            end else if (exp_unf_s) begin
              exponent <= {EXP_W{1'b0}};
            end else begin
              exponent <= exp_sum_r[EXP_W-1:0];
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
          end
        end
        default: begin
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
